// File: rtl/sp_ram.sv
// rtl/sp_ram.sv - synchronous single-port RAM with registered read port
// Reset clears the whole array and the read register; out-of-range accesses are inert.
module sp_ram #(
  parameter int N          = 4,
  parameter int DEPTH      = 16,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic [N-1:0]          addr,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] data_out
);

  localparam logic [N:0] DEPTH_W = DEPTH[N:0];

  logic [DATA_WIDTH-1:0] ram [0:DEPTH-1];
  logic [DATA_WIDTH-1:0] r_data_out;
  logic                  w_in_range;

  // One extra bit so DEPTH == 2^N compares correctly
  assign w_in_range = ({1'b0, addr} < DEPTH_W);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        ram[i] <= '0;
      end
      r_data_out <= '0;
    end else if (we) begin
      if (w_in_range) begin
        ram[addr] <= data_in;
      end
    end else begin
      r_data_out <= w_in_range ? ram[addr] : '0;
    end
  end

  assign data_out = r_data_out;

endmodule

// File: tb/tb_sp_ram.sv
// tb/tb_sp_ram.sv - scoreboard bench for sp_ram (full-depth and DEPTH=12 instances)
// Stimulus pushes model predictions; a monitor pops one per cycle after the edge.
module tb_sp_ram;

  logic       clk;
  logic       rst;
  logic       we;
  logic [3:0] addr;
  logic [7:0] data_in;
  logic [7:0] dout_a;
  logic [7:0] dout_b;

  sp_ram #(.N(4), .DEPTH(16), .DATA_WIDTH(8)) u_a (
    .clk(clk), .rst(rst), .we(we), .addr(addr), .data_in(data_in), .data_out(dout_a)
  );

  sp_ram #(.N(4), .DEPTH(12), .DATA_WIDTH(8)) u_b (
    .clk(clk), .rst(rst), .we(we), .addr(addr), .data_in(data_in), .data_out(dout_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      tag;
    logic [7:0] da;
    logic [7:0] db;
    logic [7:0] sa [16];
    logic [7:0] sb [12];
  } item_t;

  item_t q_exp [$];

  logic [7:0] m_a [16];
  logic [7:0] m_b [12];
  logic [7:0] m_da;
  logic [7:0] m_db;
  logic       model_valid;

  int checks = 0;
  int errors = 0;

  task automatic cycle(input string tag, input logic r, input logic w,
                       input logic [3:0] a, input logic [7:0] d);
    item_t it;
    @(negedge clk);
    rst     = r;
    we      = w;
    addr    = a;
    data_in = d;
    if (r) begin
      foreach (m_a[i]) m_a[i] = 8'h00;
      foreach (m_b[i]) m_b[i] = 8'h00;
      m_da = 8'h00;
      m_db = 8'h00;
      model_valid = 1'b1;
    end else if (w) begin
      m_a[a] = d;
      if (a < 12) m_b[a] = d;
    end else begin
      m_da = m_a[a];
      m_db = (a < 12) ? m_b[a] : 8'h00;
    end
    if (model_valid) begin
      it.tag = tag;
      it.da  = m_da;
      it.db  = m_db;
      foreach (m_a[i]) it.sa[i] = m_a[i];
      foreach (m_b[i]) it.sb[i] = m_b[i];
      q_exp.push_back(it);
    end
  endtask

  // Monitor: one prediction is consumed per clock edge
  initial begin
    item_t it;
    int    bad;
    forever begin
      @(posedge clk);
      #1;
      if (q_exp.size() > 0) begin
        it = q_exp.pop_front();
        checks++;
        if (dout_a !== it.da) begin
          errors++;
          $display("FAIL %s dout_a: got %02h want %02h", it.tag, dout_a, it.da);
        end
        checks++;
        if (dout_b !== it.db) begin
          errors++;
          $display("FAIL %s dout_b: got %02h want %02h", it.tag, dout_b, it.db);
        end
        bad = -1;
        for (int i = 0; i < 16; i++) if (u_a.ram[i] !== it.sa[i] && bad < 0) bad = i;
        checks++;
        if (bad >= 0) begin
          errors++;
          $display("FAIL %s ram_a[%0d]: got %02h want %02h", it.tag, bad, u_a.ram[bad], it.sa[bad]);
        end
        bad = -1;
        for (int i = 0; i < 12; i++) if (u_b.ram[i] !== it.sb[i] && bad < 0) bad = i;
        checks++;
        if (bad >= 0) begin
          errors++;
          $display("FAIL %s ram_b[%0d]: got %02h want %02h", it.tag, bad, u_b.ram[bad], it.sb[bad]);
        end
      end
    end
  end

  initial begin
    int wait_cnt;
    logic [3:0] ra;
    model_valid = 1'b0;
    m_da = 8'h00;
    m_db = 8'h00;
    rst = 1'b1; we = 1'b0; addr = '0; data_in = '0;

    cycle("init_rst", 1'b1, 1'b0, 4'd0, 8'h00);
    cycle("init_rst", 1'b1, 1'b0, 4'd0, 8'h00);
    cycle("wr_a5", 1'b0, 1'b1, 4'd3, 8'hA5);
    cycle("rd_a5", 1'b0, 1'b0, 4'd3, 8'h00);
    cycle("rst_clear", 1'b1, 1'b0, 4'd3, 8'h00);
    cycle("rd_after_rst", 1'b0, 1'b0, 4'd3, 8'h00);

    for (int i = 0; i < 16; i++) cycle("sweep_wr", 1'b0, 1'b1, 4'(i), 8'(8'h10 + i));
    for (int i = 0; i < 16; i++) cycle("sweep_rd", 1'b0, 1'b0, 4'(i), 8'h00);

    cycle("ovw_ff", 1'b0, 1'b1, 4'd0, 8'hFF);
    cycle("rd_ff", 1'b0, 1'b0, 4'd0, 8'h00);
    cycle("hold_wr3c", 1'b0, 1'b1, 4'd5, 8'h3C);
    cycle("rd_3c", 1'b0, 1'b0, 4'd5, 8'h00);

    cycle("rst_prio", 1'b1, 1'b1, 4'd7, 8'h77);
    cycle("rd_7", 1'b0, 1'b0, 4'd7, 8'h00);

    for (int i = 0; i < 12; i++) cycle("fill", 1'b0, 1'b1, 4'(i), 8'(8'hC0 + i));
    cycle("oor_wr", 1'b0, 1'b1, 4'd13, 8'h99);
    cycle("oor_rd", 1'b0, 1'b0, 4'd13, 8'h00);
    cycle("last_rd", 1'b0, 1'b0, 4'd15, 8'h00);

    for (int n = 0; n < 300; n++) begin
      ra = 4'($urandom_range(0, 15));
      cycle("rand", ($urandom_range(0, 49) == 0), $urandom_range(0, 1) == 1, ra,
            8'($urandom));
    end
    cycle("tail", 1'b0, 1'b0, 4'd0, 8'h00);

    wait_cnt = 0;
    while (q_exp.size() > 0 && wait_cnt < 20) begin
      @(posedge clk);
      wait_cnt++;
    end
    #2;
    checks++;
    if (q_exp.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending want 0", q_exp.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
